// File: rtl/iord_sequencer.sv
// iord_sequencer: arbitrates instruction fetch, data load/store and exception-vector
// fetch for the multicycle core. Drives the memory-address mux select, the memory
// write strobe and the IR/MDR/EPC/PC capture strobes. Every output is decoded from
// registered state only.

module iord_sequencer #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic       data_src,
    input  logic       data_wr,
    input  logic       exc_opcode,
    input  logic       exc_overflow,
    input  logic       exc_div0,
    output logic [2:0] iordmux,
    output logic       mem_wr,
    output logic       ir_load,
    output logic       mdr_load,
    output logic       epc_write,
    output logic       pc_vec_load,
    output logic [1:0] exc_cause,
    output logic       busy,
    output logic       done
);

    // Address mux codes
    localparam logic [2:0] MuxPc     = 3'b000;
    localparam logic [2:0] MuxAlu    = 3'b001;
    localparam logic [2:0] MuxAluOut = 3'b010;
    localparam logic [2:0] MuxVec253 = 3'b011;
    localparam logic [2:0] MuxVec254 = 3'b100;
    localparam logic [2:0] MuxVec255 = 3'b101;

    // Exception cause codes
    localparam logic [1:0] CauseNone = 2'b00;
    localparam logic [1:0] CauseOpc  = 2'b01;
    localparam logic [1:0] CauseOvf  = 2'b10;
    localparam logic [1:0] CauseDiv  = 2'b11;

    // Counter load value; first ACCESS cycle is recognised by the counter still holding it
    localparam logic [3:0] LatCnt = 4'(MEM_LAT);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        KindFetch,
        KindLoad,
        KindStore,
        KindExc
    } kind_e;

    state_e     state_q, state_d;
    kind_e      kind_q, kind_d;
    logic [2:0] code_q, code_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] cause_q, cause_d;

    // Pending exceptions, bit 0 = opcode, bit 1 = overflow, bit 2 = div0
    logic [2:0] pend_q, pend_d;
    logic [2:0] pend_eff;

    // Grant decode results
    logic       grant;
    logic [2:0] grant_exc;
    kind_e      g_kind;
    logic [2:0] g_code;
    logic [1:0] g_cause;

    // Pending set including this cycle's pulses, so a pulse is seen by the IDLE arbiter
    // in the same cycle and is never lost when it coincides with a grant
    always_comb begin
        pend_eff = pend_q | {exc_div0, exc_overflow, exc_opcode};
    end

    // IDLE arbiter: exceptions by fixed priority, then data, then fetch
    always_comb begin
        grant     = 1'b0;
        grant_exc = 3'b000;
        g_kind    = KindFetch;
        g_code    = MuxPc;
        g_cause   = cause_q;
        if (state_q == StIdle) begin
            if (pend_eff[0]) begin
                grant     = 1'b1;
                grant_exc = 3'b001;
                g_kind    = KindExc;
                g_code    = MuxVec253;
                g_cause   = CauseOpc;
            end else if (pend_eff[1]) begin
                grant     = 1'b1;
                grant_exc = 3'b010;
                g_kind    = KindExc;
                g_code    = MuxVec254;
                g_cause   = CauseOvf;
            end else if (pend_eff[2]) begin
                grant     = 1'b1;
                grant_exc = 3'b100;
                g_kind    = KindExc;
                g_code    = MuxVec255;
                g_cause   = CauseDiv;
            end else if (data_req) begin
                grant  = 1'b1;
                g_kind = data_wr ? KindStore : KindLoad;
                g_code = data_src ? MuxAluOut : MuxAlu;
            end else if (fetch_req) begin
                grant  = 1'b1;
                g_kind = KindFetch;
                g_code = MuxPc;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == 4'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Access context next values: latched on grant, counter runs during ACCESS
    always_comb begin
        kind_d  = kind_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        pend_d  = pend_eff & ~grant_exc;
        if (grant) begin
            kind_d  = g_kind;
            code_d  = g_code;
            cnt_d   = LatCnt;
            cause_d = g_cause;
        end else if (state_q == StAccess) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Access context and pending-exception registers
    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q  <= KindFetch;
            code_q  <= MuxPc;
            cnt_q   <= 4'd0;
            cause_q <= CauseNone;
            pend_q  <= 3'b000;
        end else begin
            kind_q  <= kind_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            pend_q  <= pend_d;
        end
    end

    // Output decode from registered state only
    always_comb begin
        iordmux     = MuxPc;
        mem_wr      = 1'b0;
        ir_load     = 1'b0;
        mdr_load    = 1'b0;
        epc_write   = 1'b0;
        pc_vec_load = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        exc_cause   = cause_q;
        unique case (state_q)
            StIdle: begin
                iordmux = MuxPc;
            end
            StAccess: begin
                iordmux = code_q;
                busy    = 1'b1;
                if (cnt_q == LatCnt) begin
                    mem_wr    = (kind_q == KindStore);
                    epc_write = (kind_q == KindExc);
                end
            end
            StDone: begin
                iordmux     = code_q;
                busy        = 1'b1;
                done        = 1'b1;
                ir_load     = (kind_q == KindFetch);
                mdr_load    = (kind_q == KindLoad);
                pc_vec_load = (kind_q == KindExc);
            end
            default: begin
                iordmux = MuxPc;
            end
        endcase
    end

endmodule

// File: tb/tb_iord_sequencer.sv
// Bench for iord_sequencer: two instances (MEM_LAT 1 and 3), a directed vector table,
// hand-written multi-cycle sequences and a randomized run, all checked every cycle
// against a phase-counting reference model of each access.

module tb_iord_sequencer;

    localparam int unsigned LAT1 = 1;
    localparam int unsigned LAT3 = 3;

    localparam int KF = 0;  // fetch
    localparam int KL = 1;  // load
    localparam int KS = 2;  // store
    localparam int KE = 3;  // exception vector

    typedef struct packed {
        logic reset;
        logic fetch_req;
        logic data_req;
        logic data_src;
        logic data_wr;
        logic exc_opcode;
        logic exc_overflow;
        logic exc_div0;
    } in_t;

    typedef struct {
        in_t        in;
        bit         chk;
        logic [11:0] exp;
    } vec_t;

    logic clk;
    in_t  in1, in3;

    logic [2:0] mux1, mux3;
    logic       wr1, ir1, mdr1, epc1, pcv1, busy1, done1;
    logic       wr3, ir3, mdr3, epc3, pcv3, busy3, done3;
    logic [1:0] cause1, cause3;
    logic [11:0] o1, o3;

    assign o1 = {mux1, wr1, ir1, mdr1, epc1, pcv1, cause1, busy1, done1};
    assign o3 = {mux3, wr3, ir3, mdr3, epc3, pcv3, cause3, busy3, done3};

    iord_sequencer #(.MEM_LAT(LAT1)) u_dut1 (
        .clk         (clk),
        .reset       (in1.reset),
        .fetch_req   (in1.fetch_req),
        .data_req    (in1.data_req),
        .data_src    (in1.data_src),
        .data_wr     (in1.data_wr),
        .exc_opcode  (in1.exc_opcode),
        .exc_overflow(in1.exc_overflow),
        .exc_div0    (in1.exc_div0),
        .iordmux     (mux1),
        .mem_wr      (wr1),
        .ir_load     (ir1),
        .mdr_load    (mdr1),
        .epc_write   (epc1),
        .pc_vec_load (pcv1),
        .exc_cause   (cause1),
        .busy        (busy1),
        .done        (done1)
    );

    iord_sequencer #(.MEM_LAT(LAT3)) u_dut3 (
        .clk         (clk),
        .reset       (in3.reset),
        .fetch_req   (in3.fetch_req),
        .data_req    (in3.data_req),
        .data_src    (in3.data_src),
        .data_wr     (in3.data_wr),
        .exc_opcode  (in3.exc_opcode),
        .exc_overflow(in3.exc_overflow),
        .exc_div0    (in3.exc_div0),
        .iordmux     (mux3),
        .mem_wr      (wr3),
        .ir_load     (ir3),
        .mdr_load    (mdr3),
        .epc_write   (epc3),
        .pc_vec_load (pcv3),
        .exc_cause   (cause3),
        .busy        (busy3),
        .done        (done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one in-flight access described by its phase (1..lat = access
    // cycles, lat+1 = completion cycle), plus a set of pending exceptions
    bit         m_valid[2];
    bit         m_active[2];
    int         m_phase[2];
    int         m_kind[2];
    logic [2:0] m_code[2];
    logic [2:0] m_pend[2];
    logic [1:0] m_cause[2];
    int         m_grants[2];
    int         m_abort[2];
    int         dn_cnt[2];

    function automatic int lat_of(input int i);
        return (i == 0) ? int'(LAT1) : int'(LAT3);
    endfunction

    function automatic in_t mkin(input logic r, f, d, s, w, opc, ovf, dv);
        in_t x;
        x = '{reset: r, fetch_req: f, data_req: d, data_src: s, data_wr: w,
              exc_opcode: opc, exc_overflow: ovf, exc_div0: dv};
        return x;
    endfunction

    function automatic logic [11:0] mk(input logic [2:0] mux, input logic wr, ir, mdr, epc,
                                       pcv, input logic [1:0] cause, input logic bsy, dn);
        return {mux, wr, ir, mdr, epc, pcv, cause, bsy, dn};
    endfunction

    function automatic logic [11:0] model_out(input int i);
        bit acc, dn, first;
        acc   = m_active[i] && (m_phase[i] <= lat_of(i));
        dn    = m_active[i] && (m_phase[i] == lat_of(i) + 1);
        first = acc && (m_phase[i] == 1);
        return mk(m_active[i] ? m_code[i] : 3'b000, first && (m_kind[i] == KS),
                  dn && (m_kind[i] == KF), dn && (m_kind[i] == KL), first && (m_kind[i] == KE),
                  dn && (m_kind[i] == KE), m_cause[i], m_active[i], dn);
    endfunction

    task automatic model_step(input int i, input in_t x);
        logic [2:0] pe;
        if (x.reset) begin
            if (m_active[i] && m_phase[i] <= lat_of(i)) m_abort[i]++;
            m_active[i] = 1'b0;
            m_pend[i]   = 3'b000;
            m_cause[i]  = 2'b00;
            m_valid[i]  = 1'b1;
            return;
        end
        pe = m_pend[i] | {x.exc_div0, x.exc_overflow, x.exc_opcode};
        if (m_active[i]) begin
            if (m_phase[i] == lat_of(i) + 1) m_active[i] = 1'b0;
            else m_phase[i]++;
        end else begin
            m_active[i] = 1'b1;
            m_phase[i]  = 1;
            if (pe[0]) begin
                pe[0] = 1'b0; m_kind[i] = KE; m_code[i] = 3'd3; m_cause[i] = 2'd1;
            end else if (pe[1]) begin
                pe[1] = 1'b0; m_kind[i] = KE; m_code[i] = 3'd4; m_cause[i] = 2'd2;
            end else if (pe[2]) begin
                pe[2] = 1'b0; m_kind[i] = KE; m_code[i] = 3'd5; m_cause[i] = 2'd3;
            end else if (x.data_req) begin
                m_kind[i] = x.data_wr ? KS : KL;
                m_code[i] = x.data_src ? 3'd2 : 3'd1;
            end else if (x.fetch_req) begin
                m_kind[i] = KF;
                m_code[i] = 3'd0;
            end else begin
                m_active[i] = 1'b0;
            end
            if (m_active[i]) m_grants[i]++;
        end
        m_pend[i] = pe;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %b want %b (mux,wr,ir,mdr,epc,pcv,cause,busy,done)",
                     name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Compare both instances with the model, then advance one clock
    task automatic cycle();
        logic [11:0] ov;
        for (int i = 0; i < 2; i++) begin
            ov = (i == 0) ? o1 : o3;
            if (m_valid[i]) begin
                check((i == 0) ? "model_lat1" : "model_lat3", ov, model_out(i));
                n_checks++;
                if (ov[11:10] == 2'b11) begin
                    n_errors++;
                    $display("FAIL illegal_iordmux inst %0d: got %b want 0xx/100/101", i,
                             ov[11:9]);
                end
            end
            if (ov[0] === 1'b1) dn_cnt[i]++;
        end
        @(posedge clk);
        model_step(0, in1);
        model_step(1, in3);
        #1;
    endtask

    task automatic step3(input string name, input in_t x, input logic [11:0] e);
        in3 = x;
        check(name, o3, e);
        cycle();
    endtask

    vec_t tbl[24];
    in_t  z, st, rsts;
    int   req[2];
    logic rsrc[2], rwr[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_active[i] = 0; m_phase[i] = 0; m_kind[i] = 0;
            m_code[i] = 0; m_pend[i] = 0; m_cause[i] = 0;
            m_grants[i] = 0; m_abort[i] = 0; dn_cnt[i] = 0; req[i] = 0;
            rsrc[i] = 0; rwr[i] = 0;
        end
        z    = mkin(0, 0, 0, 0, 0, 0, 0, 0);
        st   = mkin(0, 0, 1, 1, 1, 0, 0, 0);
        rsts = mkin(1, 0, 0, 0, 0, 0, 0, 0);

        // Directed table for the MEM_LAT=1 instance
        tbl[0]  = '{mkin(1, 0, 0, 0, 0, 0, 0, 0), 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{mkin(1, 0, 0, 0, 0, 0, 0, 0), 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{mkin(0, 1, 0, 0, 0, 0, 0, 0), 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{mkin(0, 1, 0, 0, 0, 0, 0, 0), 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[4]  = '{mkin(0, 0, 0, 0, 0, 0, 0, 0), 1, mk(0, 0, 1, 0, 0, 0, 0, 1, 1)};
        tbl[5]  = '{mkin(0, 1, 1, 0, 0, 0, 1, 0), 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[6]  = '{mkin(0, 1, 1, 0, 0, 0, 0, 0), 1, mk(4, 0, 0, 0, 1, 0, 2, 1, 0)};
        tbl[7]  = '{mkin(0, 1, 1, 0, 0, 0, 0, 0), 1, mk(4, 0, 0, 0, 0, 1, 2, 1, 1)};
        tbl[8]  = '{mkin(0, 1, 1, 0, 0, 0, 0, 0), 1, mk(0, 0, 0, 0, 0, 0, 2, 0, 0)};
        tbl[9]  = '{mkin(0, 1, 1, 0, 0, 0, 0, 0), 1, mk(1, 0, 0, 0, 0, 0, 2, 1, 0)};
        tbl[10] = '{mkin(0, 1, 0, 0, 0, 0, 0, 0), 1, mk(1, 0, 0, 1, 0, 0, 2, 1, 1)};
        tbl[11] = '{mkin(0, 1, 0, 0, 0, 0, 0, 0), 1, mk(0, 0, 0, 0, 0, 0, 2, 0, 0)};
        tbl[12] = '{mkin(0, 1, 0, 0, 0, 1, 0, 1), 1, mk(0, 0, 0, 0, 0, 0, 2, 1, 0)};
        tbl[13] = '{mkin(0, 0, 0, 0, 0, 0, 0, 0), 1, mk(0, 0, 1, 0, 0, 0, 2, 1, 1)};
        tbl[14] = '{mkin(0, 0, 0, 0, 0, 0, 0, 0), 1, mk(0, 0, 0, 0, 0, 0, 2, 0, 0)};
        tbl[15] = '{mkin(0, 0, 0, 0, 0, 0, 0, 0), 1, mk(3, 0, 0, 0, 1, 0, 1, 1, 0)};
        tbl[16] = '{mkin(0, 0, 0, 0, 0, 0, 0, 0), 1, mk(3, 0, 0, 0, 0, 1, 1, 1, 1)};
        tbl[17] = '{mkin(0, 0, 0, 0, 0, 0, 0, 0), 1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0)};
        tbl[18] = '{mkin(0, 0, 0, 0, 0, 0, 0, 0), 1, mk(5, 0, 0, 0, 1, 0, 3, 1, 0)};
        tbl[19] = '{mkin(0, 0, 0, 0, 0, 0, 0, 0), 1, mk(5, 0, 0, 0, 0, 1, 3, 1, 1)};
        tbl[20] = '{mkin(0, 0, 1, 1, 1, 0, 0, 0), 1, mk(0, 0, 0, 0, 0, 0, 3, 0, 0)};
        tbl[21] = '{mkin(0, 0, 1, 1, 1, 0, 0, 0), 1, mk(2, 1, 0, 0, 0, 0, 3, 1, 0)};
        tbl[22] = '{mkin(0, 0, 0, 0, 0, 0, 0, 0), 1, mk(2, 0, 0, 0, 0, 0, 3, 1, 1)};
        tbl[23] = '{mkin(0, 0, 0, 0, 0, 0, 0, 0), 1, mk(0, 0, 0, 0, 0, 0, 3, 0, 0)};

        // Initial reset of both instances
        in1 = rsts;
        in3 = rsts;
        #1;
        cycle();
        cycle();
        in3 = z;

        for (int k = 0; k < 24; k++) begin
            in1 = tbl[k].in;
            if (tbl[k].chk) check($sformatf("table_row%0d", k), o1, tbl[k].exp);
            cycle();
        end
        in1 = z;

        // Store through ALUOut, MEM_LAT=3
        step3("st3_idle",  st, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step3("st3_acc1",  st, mk(2, 1, 0, 0, 0, 0, 0, 1, 0));
        step3("st3_acc2",  st, mk(2, 0, 0, 0, 0, 0, 0, 1, 0));
        step3("st3_acc3",  st, mk(2, 0, 0, 0, 0, 0, 0, 1, 0));
        step3("st3_done",  z,  mk(2, 0, 0, 0, 0, 0, 0, 1, 1));
        step3("st3_after", z,  mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Reset in the first ACCESS cycle of a store
        step3("rsA_grant", st, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step3("rsA_acc1",  mkin(1, 0, 1, 1, 1, 0, 0, 0), mk(2, 1, 0, 0, 0, 0, 0, 1, 0));
        step3("rsA_post",  z,  mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step3("rsA_post2", z,  mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Overflow latched mid-store, then reset: must never be serviced
        step3("rsB_grant", st, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        step3("rsB_acc1",  mkin(0, 0, 1, 1, 1, 0, 1, 0), mk(2, 1, 0, 0, 0, 0, 0, 1, 0));
        step3("rsB_acc2",  mkin(1, 0, 1, 1, 1, 0, 0, 0), mk(2, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 4; k++) begin
            step3($sformatf("rsB_quiet%0d", k), z, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        end

        // Randomized run on both instances with request hold-until-done behaviour
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 2; i++) begin
                in_t x;
                logic dn;
                dn = (i == 0) ? done1 : done3;
                x = z;
                if (dn === 1'b1 && $urandom_range(9) != 0) begin
                    req[i] = 0;
                end else if (req[i] == 0 && $urandom_range(3) == 0) begin
                    req[i]  = int'($urandom_range(2, 1));
                    rsrc[i] = 1'($urandom_range(1));
                    rwr[i]  = 1'($urandom_range(1));
                end
                x.fetch_req    = (req[i] == 1);
                x.data_req     = (req[i] == 2);
                x.data_src     = rsrc[i];
                x.data_wr      = rwr[i];
                x.exc_opcode   = ($urandom_range(15) == 0);
                x.exc_overflow = ($urandom_range(15) == 0);
                x.exc_div0     = ($urandom_range(15) == 0);
                x.reset        = ($urandom_range(499) == 0);
                if (x.reset) req[i] = 0;
                if (i == 0) in1 = x;
                else in3 = x;
            end
            cycle();
        end

        // Drain in-flight and pending work
        in1 = z;
        in3 = z;
        for (int k = 0; k < 40; k++) cycle();

        check_int("done_vs_grant_lat1", dn_cnt[0], m_grants[0] - m_abort[0]);
        check_int("done_vs_grant_lat3", dn_cnt[1], m_grants[1] - m_abort[1]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
